// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core-phase encodings, LSU state type and width defaults
package gpu_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_ADDR_BITS = 8;

  // Core phase encodings driven by the scheduler
  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/thread_lsu.sv
// rtl/thread_lsu.sv - per-thread load/store unit; optional predicate skip under THREAD_LSU_PREDICATE_EN
module thread_lsu
  import gpu_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic                 decoded_predicate_on,
  input  logic                 decoded_always_execute,
  input  logic                 predicate,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  lsu_state_t           state, state_d;
  logic                 read_valid_d, write_valid_d;
  logic [ADDR_BITS-1:0] read_addr_d, write_addr_d;
  logic [DATA_BITS-1:0] write_data_d, lsu_out_d;
  logic                 is_mem_op;
  logic                 skip;

  assign is_mem_op = decoded_mem_read_enable | decoded_mem_write_enable;
  assign lsu_state = state;

`ifdef THREAD_LSU_PREDICATE_EN
  // A predicated-off instruction completes without touching memory
  assign skip = decoded_predicate_on & ~decoded_always_execute & ~predicate;
`else
  logic unused_predicate_inputs;
  assign unused_predicate_inputs = decoded_predicate_on ^ decoded_always_execute ^ predicate;
  assign skip = 1'b0;
`endif

  // Next-state and next-output logic; everything holds while the thread is disabled
  always_comb begin
    state_d       = state;
    read_valid_d  = mem_read_valid;
    read_addr_d   = mem_read_address;
    write_valid_d = mem_write_valid;
    write_addr_d  = mem_write_address;
    write_data_d  = mem_write_data;
    lsu_out_d     = lsu_out;
    if (enable) begin
      case (state)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST && is_mem_op) begin
            state_d = skip ? LSU_DONE : LSU_REQUESTING;
          end
        end
        LSU_REQUESTING: begin
          // Read wins when the decoder flags both
          if (decoded_mem_read_enable) begin
            state_d      = LSU_WAITING;
            read_valid_d = 1'b1;
            read_addr_d  = rs[ADDR_BITS-1:0];
          end else if (decoded_mem_write_enable) begin
            state_d       = LSU_WAITING;
            write_valid_d = 1'b1;
            write_addr_d  = rs[ADDR_BITS-1:0];
            write_data_d  = rt;
          end else begin
            state_d = LSU_DONE;
          end
        end
        LSU_WAITING: begin
          // Only the ready matching the raised valid completes; UPDATE here does not abort
          if (mem_read_valid && mem_read_ready) begin
            state_d      = LSU_DONE;
            read_valid_d = 1'b0;
            lsu_out_d    = mem_read_data;
          end else if (mem_write_valid && mem_write_ready) begin
            state_d       = LSU_DONE;
            write_valid_d = 1'b0;
          end
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE) begin
            state_d = LSU_IDLE;
          end
        end
        default: state_d = LSU_IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= LSU_IDLE;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
    end else begin
      state             <= state_d;
      mem_read_valid    <= read_valid_d;
      mem_read_address  <= read_addr_d;
      mem_write_valid   <= write_valid_d;
      mem_write_address <= write_addr_d;
      mem_write_data    <= write_data_d;
      lsu_out           <= lsu_out_d;
    end
  end

endmodule

// File: tb/tb_thread_lsu.sv
// tb/tb_thread_lsu.sv - scoreboard bench for thread_lsu; predicate cases follow THREAD_LSU_PREDICATE_EN
module tb_thread_lsu;
  import gpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       decoded_mem_read_enable, decoded_mem_write_enable;
  logic       decoded_predicate_on, decoded_always_execute, predicate;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;

  thread_lsu dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(decoded_mem_read_enable),
    .decoded_mem_write_enable(decoded_mem_write_enable),
    .decoded_predicate_on(decoded_predicate_on),
    .decoded_always_execute(decoded_always_execute),
    .predicate(predicate), .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_read;
    logic [7:0] addr;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  int         tests = 0;
  int         errors = 0;
  logic [7:0] exp_lsu = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: push the expected transfer, then serve it from the memory side
  task automatic run_op(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input int delay);
    sb_t it;
    it.is_read = rd;
    it.addr    = a;
    it.data    = d;
    sb_q.push_back(it);
    decoded_mem_read_enable  = rd;
    decoded_mem_write_enable = wr;
    rs = a;
    rt = d;
    core_state = CORE_REQUEST;
    step();
    check("req_state", lsu_state, LSU_REQUESTING);
    core_state = CORE_WAIT;
    step();
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    it = sb_q.pop_front();
    for (int k = 0; k <= delay; k++) begin
      check("wait_state", lsu_state, LSU_WAITING);
      if (it.is_read) begin
        check("rd_valid", mem_read_valid, 1);
        check("rd_addr", mem_read_address, it.addr);
        check("wr_valid_idle", mem_write_valid, 0);
      end else begin
        check("wr_valid", mem_write_valid, 1);
        check("wr_addr", mem_write_address, it.addr);
        check("wr_data", mem_write_data, it.data);
        check("rd_valid_idle", mem_read_valid, 0);
      end
      if (k == delay) begin
        if (it.is_read) begin
          mem_read_ready = 1'b1;
          mem_read_data  = it.data;
        end else begin
          mem_write_ready = 1'b1;
        end
      end
      step();
    end
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'hEE;
    if (it.is_read) exp_lsu = it.data;
    check("done_state", lsu_state, LSU_DONE);
    check("done_rd_valid", mem_read_valid, 0);
    check("done_wr_valid", mem_write_valid, 0);
    check("done_lsu_out", lsu_out, exp_lsu);
    core_state = CORE_UPDATE;
    step();
    check("upd_state", lsu_state, LSU_IDLE);
    core_state = CORE_IDLE;
    decoded_mem_read_enable  = 1'b0;
    decoded_mem_write_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    core_state = CORE_IDLE;
    decoded_mem_read_enable = 1'b0;
    decoded_mem_write_enable = 1'b0;
    decoded_predicate_on = 1'b0;
    decoded_always_execute = 1'b0;
    predicate = 1'b1;
    rs = 8'h00;
    rt = 8'h00;
    mem_read_ready = 1'b0;
    mem_read_data = 8'h00;
    mem_write_ready = 1'b0;
    step();
    step();
    check("rst_state", lsu_state, LSU_IDLE);
    check("rst_rvalid", mem_read_valid, 0);
    check("rst_wvalid", mem_write_valid, 0);
    check("rst_raddr", mem_read_address, 0);
    check("rst_waddr", mem_write_address, 0);
    check("rst_wdata", mem_write_data, 0);
    check("rst_out", lsu_out, 0);
    reset = 1'b0;
    step();

    run_op(1'b1, 1'b0, 8'h2A, 8'h5C, 0);
    run_op(1'b0, 1'b1, 8'h10, 8'hA7, 4);
    run_op(1'b1, 1'b1, 8'h03, 8'h91, 1);

    // Predicated-off load
    decoded_predicate_on   = 1'b1;
    decoded_always_execute = 1'b0;
    predicate              = 1'b0;
`ifdef THREAD_LSU_PREDICATE_EN
    decoded_mem_read_enable = 1'b1;
    rs = 8'h44;
    core_state = CORE_REQUEST;
    step();
    check("skip_state", lsu_state, LSU_DONE);
    check("skip_rvalid", mem_read_valid, 0);
    core_state = CORE_WAIT;
    step();
    check("skip_rvalid2", mem_read_valid, 0);
    check("skip_out", lsu_out, exp_lsu);
    core_state = CORE_UPDATE;
    step();
    check("skip_idle", lsu_state, LSU_IDLE);
    core_state = CORE_IDLE;
    decoded_mem_read_enable = 1'b0;
`else
    run_op(1'b1, 1'b0, 8'h44, 8'h6D, 0);
`endif
    decoded_predicate_on = 1'b0;
    predicate            = 1'b1;

    // Reset while waiting with valid high
    decoded_mem_read_enable = 1'b1;
    rs = 8'h77;
    core_state = CORE_REQUEST;
    step();
    core_state = CORE_WAIT;
    step();
    check("pre_rst_valid", mem_read_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_lsu = 8'h00;
    check("mid_rst_valid", mem_read_valid, 0);
    check("mid_rst_state", lsu_state, LSU_IDLE);
    decoded_mem_read_enable = 1'b0;
    core_state = CORE_IDLE;
    mem_read_ready = 1'b1;
    mem_read_data  = 8'hBB;
    step();
    step();
    check("late_rdy_state", lsu_state, LSU_IDLE);
    check("late_rdy_out", lsu_out, exp_lsu);
    mem_read_ready = 1'b0;

    // Disabled thread during REQUEST
    enable = 1'b0;
    decoded_mem_write_enable = 1'b1;
    rs = 8'h55;
    core_state = CORE_REQUEST;
    step();
    step();
    check("dis_state", lsu_state, LSU_IDLE);
    check("dis_wvalid", mem_write_valid, 0);
    check("dis_rvalid", mem_read_valid, 0);
    enable = 1'b1;
    core_state = CORE_IDLE;
    decoded_mem_write_enable = 1'b0;
    step();

    run_op(1'b1, 1'b0, 8'hF0, 8'h12, 2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Hard cap so a stuck handshake cannot hang the run
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
